// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises the split instruction/data ports onto one
// physical memory port and holds each completed response until the
// pipeline advances.
//
// Ports:
//   clk, reset              clock, async active-high reset
//   pipe_advance            pipeline load strobe, consumes both buffers
//   imem_address/read       fetch request
//   imem_rdata/resp         buffered fetch result
//   mem_address/wdata       data request address and store data
//   mem_read/write          load / store request
//   mem_byte_enable         store lane enables
//   mem_rdata/resp          buffered load result
//   pmem_address/wdata      physical request (registered)
//   pmem_read/write         physical strobes (registered)
//   pmem_byte_enable        physical lane enables (registered)
//   pmem_rdata/resp         physical completion

module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_advance,

    input  logic [15:0] imem_address,
    input  logic        imem_read,
    output logic [15:0] imem_rdata,
    output logic        imem_resp,

    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    output logic [15:0] mem_rdata,
    output logic        mem_resp,

    output logic [15:0] pmem_address,
    output logic [15:0] pmem_wdata,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [1:0]  pmem_byte_enable,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } state_e;

    state_e      state_q, state_d;

    logic [15:0] req_addr_q, req_addr_d;
    logic [15:0] req_wdata_q, req_wdata_d;
    logic [1:0]  req_be_q, req_be_d;
    logic        req_rd_q, req_rd_d;
    logic        req_wr_q, req_wr_d;

    logic        ibuf_valid_q, ibuf_valid_d;
    logic [15:0] ibuf_addr_q, ibuf_addr_d;
    logic [15:0] ibuf_data_q, ibuf_data_d;

    logic        dbuf_valid_q, dbuf_valid_d;
    logic [15:0] dbuf_addr_q, dbuf_addr_d;
    logic [15:0] dbuf_data_q, dbuf_data_d;
    // dbuf_op: 1 = store, 0 = load
    logic        dbuf_op_q, dbuf_op_d;

    logic        i_hit;
    logic        d_hit;
    logic        i_pend;
    logic        d_pend;
    logic        d_req;

    // Hit / response logic
    always_comb begin
        d_req  = mem_read || mem_write;
        i_hit  = ibuf_valid_q && (ibuf_addr_q == imem_address);
        // op match keeps a load result from answering a store to the
        // same address (and vice versa)
        d_hit  = dbuf_valid_q && (dbuf_addr_q == mem_address)
                 && (dbuf_op_q == mem_write);
        i_pend = imem_read && !i_hit;
        d_pend = d_req && !d_hit;
    end

    assign imem_resp  = i_hit && imem_read;
    assign mem_resp   = d_hit && d_req;
    assign imem_rdata = ibuf_data_q;
    assign mem_rdata  = dbuf_data_q;

    assign pmem_address     = req_addr_q;
    assign pmem_wdata       = req_wdata_q;
    assign pmem_read        = req_rd_q;
    assign pmem_write       = req_wr_q;
    assign pmem_byte_enable = req_be_q;

    // Next-state and buffer update
    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_be_d     = req_be_q;
        req_rd_d     = req_rd_q;
        req_wr_d     = req_wr_q;

        ibuf_addr_d  = ibuf_addr_q;
        ibuf_data_d  = ibuf_data_q;
        dbuf_addr_d  = dbuf_addr_q;
        dbuf_data_d  = dbuf_data_q;
        dbuf_op_d    = dbuf_op_q;

        // advance consumes both results; a completion at the same edge
        // overrides this below since it belongs to the new request
        ibuf_valid_d = ibuf_valid_q && !pipe_advance;
        dbuf_valid_d = dbuf_valid_q && !pipe_advance;

        unique case (state_q)
            IDLE: begin
                if (d_pend) begin
                    state_d     = D_ACC;
                    req_addr_d  = mem_address;
                    req_wdata_d = mem_wdata;
                    req_be_d    = mem_write ? mem_byte_enable : 2'b11;
                    req_rd_d    = mem_read;
                    req_wr_d    = mem_write;
                end else if (i_pend) begin
                    state_d     = I_ACC;
                    req_addr_d  = imem_address;
                    req_wdata_d = 16'h0000;
                    req_be_d    = 2'b11;
                    req_rd_d    = 1'b1;
                    req_wr_d    = 1'b0;
                end
            end

            I_ACC: begin
                if (pmem_resp) begin
                    state_d      = IDLE;
                    ibuf_data_d  = pmem_rdata;
                    ibuf_addr_d  = req_addr_q;
                    ibuf_valid_d = 1'b1;
                    req_addr_d   = 16'h0000;
                    req_wdata_d  = 16'h0000;
                    req_be_d     = 2'b00;
                    req_rd_d     = 1'b0;
                    req_wr_d     = 1'b0;
                end
            end

            D_ACC: begin
                if (pmem_resp) begin
                    state_d      = IDLE;
                    dbuf_data_d  = pmem_rdata;
                    dbuf_addr_d  = req_addr_q;
                    dbuf_op_d    = req_wr_q;
                    dbuf_valid_d = 1'b1;
                    req_addr_d   = 16'h0000;
                    req_wdata_d  = 16'h0000;
                    req_be_d     = 2'b00;
                    req_rd_d     = 1'b0;
                    req_wr_d     = 1'b0;
                end
            end

            default: begin
                state_d  = IDLE;
                req_be_d = 2'b00;
                req_rd_d = 1'b0;
                req_wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            req_addr_q   <= 16'h0000;
            req_wdata_q  <= 16'h0000;
            req_be_q     <= 2'b00;
            req_rd_q     <= 1'b0;
            req_wr_q     <= 1'b0;
            ibuf_valid_q <= 1'b0;
            ibuf_addr_q  <= 16'h0000;
            ibuf_data_q  <= 16'h0000;
            dbuf_valid_q <= 1'b0;
            dbuf_addr_q  <= 16'h0000;
            dbuf_data_q  <= 16'h0000;
            dbuf_op_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_be_q     <= req_be_d;
            req_rd_q     <= req_rd_d;
            req_wr_q     <= req_wr_d;
            ibuf_valid_q <= ibuf_valid_d;
            ibuf_addr_q  <= ibuf_addr_d;
            ibuf_data_q  <= ibuf_data_d;
            dbuf_valid_q <= dbuf_valid_d;
            dbuf_addr_q  <= dbuf_addr_d;
            dbuf_data_q  <= dbuf_data_d;
            dbuf_op_q    <= dbuf_op_d;
        end
    end

endmodule
